// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes opposite last_grant.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic valid,
  output logic pick_d
);
  assign valid  = i_req | d_req;
  assign pick_d = d_req & (~i_req | (last_grant == OWNER_I));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache and D-cache miss paths, one
// transaction at a time, with registered memory outputs and a ready pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              i_mem_ready,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_d
);
  arb_state_e        state;
  logic              last_grant;
  logic              pick_valid, pick_d;
  logic              win_rd, win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  mem_arb_rr_pick u_pick (
    .i_req      (i_mem_read | i_mem_write),
    .d_req      (d_mem_read | d_mem_write),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .pick_d     (pick_d)
  );

  assign win_rd    = pick_d ? d_mem_read  : i_mem_read;
  assign win_wr    = pick_d ? d_mem_write : i_mem_write;
  assign win_addr  = pick_d ? d_mem_addr  : i_mem_addr;
  assign win_wdata = pick_d ? d_mem_wdata : i_mem_wdata;

  // grant_d doubles as the owner of the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= OWNER_D;
      grant_d     <= OWNER_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          // read+write together is tolerated and treated as a write
          mem_read   <= win_rd & ~win_wr;
          mem_write  <= win_wr;
          mem_addr   <= win_addr;
          mem_wdata  <= win_wdata;
          grant_d    <= pick_d;
          last_grant <= pick_d;
          state      <= BUSY;
        end
        BUSY: if (mem_ready) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (grant_d == OWNER_D) begin
            d_mem_rdata <= mem_rdata;
            d_mem_ready <= 1'b1;
          end else begin
            i_mem_rdata <= mem_rdata;
            i_mem_ready <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          i_mem_ready <= 1'b0;
          d_mem_ready <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
